// File: rtl/line_mem_responder.sv
// Backing-memory responder for the direct-mapped cache: services line fills and
// writebacks one at a time and answers after a fixed, programmable latency.
module line_mem_responder #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned B       = 4,
   parameter int unsigned DEPTH   = 256,
   parameter int unsigned LATENCY = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req_v_i,
   output logic               req_ready_o,
   input  logic               req_we_i,
   input  logic [WIDTH-1:0]   req_addr_i,
   input  logic [B*8-1:0]     req_data_i,
   output logic               resp_v_o,
   input  logic               resp_ready_i,
   output logic               resp_we_o,
   output logic [B*8-1:0]     resp_data_o,
   output logic               resp_err_o
);

   localparam int unsigned DW    = B * 8;
   localparam int unsigned OFF_W = $clog2(B);
   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = 8;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t           state;
   state_t           state_next;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;

   logic [WIDTH-1:0] addr_q;
   logic             we_q;
   logic [DW-1:0]    data_q;

   logic             accept_c;
   logic             commit_c;
   logic             release_c;
   logic [WIDTH-1:0] c_addr;
   logic             c_we;
   logic [DW-1:0]    c_data;
   logic [IDX_W-1:0] c_idx;
   logic             c_oor;

   logic [DW-1:0]    mem [DEPTH];

   // Next-state logic; with LATENCY==1 the access commits straight from the request inputs
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      accept_c   = 1'b0;
      commit_c   = 1'b0;
      release_c  = 1'b0;
      c_addr     = addr_q;
      c_we       = we_q;
      c_data     = data_q;
      case (state)
         IDLE: begin
            if (req_v_i && req_ready_o) begin
               accept_c = 1'b1;
               cnt_next = CNT_W'(LATENCY - 1);
               if (LATENCY == 1) begin
                  commit_c   = 1'b1;
                  c_addr     = req_addr_i;
                  c_we       = req_we_i;
                  c_data     = req_data_i;
                  state_next = RESP;
               end else begin
                  state_next = WAIT;
               end
            end
         end
         WAIT: begin
            cnt_next = cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
               commit_c   = 1'b1;
               state_next = RESP;
            end
         end
         RESP: begin
            if (resp_ready_i) begin
               release_c  = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign c_idx = c_addr[OFF_W +: IDX_W];
   assign c_oor = |(c_addr >> (OFF_W + IDX_W));

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // Request latch, storage and registered response outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
         addr_q      <= '0;
         we_q        <= 1'b0;
         data_q      <= '0;
         req_ready_o <= 1'b1;
         resp_v_o    <= 1'b0;
         resp_we_o   <= 1'b0;
         resp_data_o <= '0;
         resp_err_o  <= 1'b0;
      end else begin
         if (accept_c) begin
            addr_q <= req_addr_i;
            we_q   <= req_we_i;
            data_q <= req_data_i;
         end
         if (commit_c) begin
            resp_we_o  <= c_we;
            resp_err_o <= c_oor;
            if (c_we) begin
               resp_data_o <= '0;
               if (!c_oor) mem[c_idx] <= c_data;
            end else begin
               resp_data_o <= c_oor ? '0 : mem[c_idx];
            end
         end
         if (release_c) begin
            resp_data_o <= '0;
            resp_err_o  <= 1'b0;
         end
         req_ready_o <= (state_next == IDLE);
         resp_v_o    <= (state_next == RESP);
      end
   end

endmodule

// File: tb/tb_line_mem_responder.sv
// Scoreboard bench for line_mem_responder: a LATENCY=4 instance under directed and
// random traffic, plus a LATENCY=1 instance for back-to-back timing.
module tb_line_mem_responder;

   localparam int LAT   = 4;
   localparam int LAT1  = 1;
   localparam int B     = 4;
   localparam int DEPTH = 256;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   always #5 clk = ~clk;

   logic        req_v = 1'b0, req_ready, req_we = 1'b0;
   logic [31:0] req_addr = '0, req_data = '0;
   logic        resp_v, resp_ready = 1'b0, resp_we, resp_err;
   logic [31:0] resp_data;

   logic        req_v1 = 1'b0, req_ready1, req_we1 = 1'b0;
   logic [31:0] req_addr1 = '0, req_data1 = '0;
   logic        resp_v1, resp_we1, resp_err1;
   logic        resp_ready1 = 1'b1;
   logic [31:0] resp_data1;

   line_mem_responder #(.WIDTH(32), .B(B), .DEPTH(DEPTH), .LATENCY(LAT)) u_dut (
      .clk(clk), .rst(rst), .req_v_i(req_v), .req_ready_o(req_ready), .req_we_i(req_we),
      .req_addr_i(req_addr), .req_data_i(req_data), .resp_v_o(resp_v),
      .resp_ready_i(resp_ready), .resp_we_o(resp_we), .resp_data_o(resp_data),
      .resp_err_o(resp_err));

   line_mem_responder #(.WIDTH(32), .B(B), .DEPTH(DEPTH), .LATENCY(LAT1)) u_dut1 (
      .clk(clk), .rst(rst), .req_v_i(req_v1), .req_ready_o(req_ready1), .req_we_i(req_we1),
      .req_addr_i(req_addr1), .req_data_i(req_data1), .resp_v_o(resp_v1),
      .resp_ready_i(resp_ready1), .resp_we_o(resp_we1), .resp_data_o(resp_data1),
      .resp_err_o(resp_err1));

   typedef struct {
      logic        we;
      logic [31:0] data;
      logic        err;
      int          acc;
   } exp_t;

   exp_t        q[$];
   exp_t        q1[$];
   logic [31:0] ref_mem [DEPTH];
   int          checks = 0;
   int          failures = 0;
   int          edge_cnt = 0;
   int          rr_mode = 0;
   bit          prev_v = 1'b0;
   bit          prev_v1 = 1'b0;

   always @(posedge clk) edge_cnt++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h time=%0t", name, act, exp, $time);
      end
   endtask

   // Reference memory: a line is addr/B modulo DEPTH; anything at or past B*DEPTH is an error
   task automatic predict(input logic we, input logic [31:0] addr, input logic [31:0] data,
                          output exp_t e);
      int idx;
      idx   = int'((addr / B) % DEPTH);
      e.we  = we;
      e.err = (addr >= 32'(B * DEPTH));
      e.acc = 0;
      if (we) begin
         e.data = '0;
         if (!e.err) ref_mem[idx] = data;
      end else begin
         e.data = e.err ? 32'h0 : ref_mem[idx];
      end
   endtask

   always @(posedge clk) begin
      #1;
      case (rr_mode)
         0:       resp_ready = ($urandom_range(0, 2) != 0);
         1:       resp_ready = 1'b0;
         default: resp_ready = 1'b1;
      endcase
   end

   always begin
      @(posedge clk);
      #2;
      if (rst) begin
         prev_v = 1'b0;
      end else begin
         check("req_ready", req_ready, 32'(q.size() == 0));
         if (resp_v) begin
            if (q.size() == 0) begin
               check("unexpected_resp", resp_v, 0);
            end else begin
               if (!prev_v) check("latency", edge_cnt, q[0].acc + LAT - 1);
               check("resp_data", resp_data, q[0].data);
               check("resp_err", resp_err, q[0].err);
               check("resp_we", resp_we, q[0].we);
               if (resp_ready) void'(q.pop_front());
            end
         end else begin
            check("idle_data", resp_data, 0);
            check("idle_err", resp_err, 0);
         end
         prev_v = resp_v;
      end
   end

   always begin
      @(posedge clk);
      #2;
      if (rst) begin
         prev_v1 = 1'b0;
      end else begin
         check("req_ready1", req_ready1, 32'(q1.size() == 0));
         if (resp_v1) begin
            if (q1.size() == 0) begin
               check("unexpected_resp1", resp_v1, 0);
            end else begin
               if (!prev_v1) check("latency1", edge_cnt, q1[0].acc + LAT1 - 1);
               check("resp_data1", resp_data1, q1[0].data);
               check("resp_err1", resp_err1, q1[0].err);
               check("resp_we1", resp_we1, q1[0].we);
               if (resp_ready1) void'(q1.pop_front());
            end
         end
         prev_v1 = resp_v1;
      end
   end

   // Called at a negedge; holds reset over two edges and checks the cleared outputs
   task automatic apply_reset();
      rst = 1'b1;
      q.delete();
      q1.delete();
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("rst_ready", req_ready, 1);
      check("rst_resp_v", resp_v, 0);
      check("rst_resp_we", resp_we, 0);
      check("rst_resp_data", resp_data, 0);
      check("rst_resp_err", resp_err, 0);
   endtask

   task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] data);
      int   n = 0;
      exp_t e;
      @(negedge clk);
      while (!req_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         check("accept_timeout", req_ready, 1);
         return;
      end
      req_v    = 1'b1;
      req_we   = we;
      req_addr = addr;
      req_data = data;
      predict(we, addr, data, e);
      e.acc = edge_cnt + 1;
      q.push_back(e);
      @(posedge clk);
      #1;
      req_v    = 1'b0;
      req_we   = 1'($urandom);
      req_addr = $urandom;
      req_data = $urandom;
   endtask

   task automatic drain();
      int n = 0;
      while ((q.size() != 0 || q1.size() != 0) && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("drain_timeout", 32'(q.size() + q1.size()), 0);
   endtask

   initial begin
      int        n;
      int        prev_acc;
      logic [31:0] addr;
      exp_t      e;

      @(negedge clk);
      apply_reset();

      rr_mode = 0;
      do_req(1'b0, 32'h0000_0010, 32'h0);
      do_req(1'b1, 32'h0000_0040, 32'hDEAD_BEEF);
      do_req(1'b0, 32'h0000_0042, 32'h0);
      do_req(1'b1, 32'h0000_0400, 32'hCAFE_F00D);
      do_req(1'b0, 32'h0000_0000, 32'h0);
      drain();

      // Stall the response for five cycles while a competing request is presented
      rr_mode = 1;
      do_req(1'b0, 32'h0000_0040, 32'h0);
      n = 0;
      while (!resp_v && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("hold_resp_v", resp_v, 1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         req_v    = 1'b1;
         req_we   = 1'b1;
         req_addr = 32'h0000_0044;
         req_data = $urandom;
         check("hold_ready", req_ready, 0);
         check("hold_data", resp_data, 32'hDEAD_BEEF);
      end
      @(negedge clk);
      req_v   = 1'b0;
      rr_mode = 2;
      drain();
      rr_mode = 0;

      // Reset two cycles into the wait of a write: no response and nothing stored
      do_req(1'b1, 32'h0000_0080, 32'h1234_5678);
      repeat (2) @(negedge clk);
      apply_reset();
      do_req(1'b0, 32'h0000_0080, 32'h0);
      drain();

      for (int i = 0; i < 150; i++) begin
         case ($urandom_range(0, 7))
            0:       addr = $urandom;
            1, 2, 3: addr = 32'($urandom_range(0, 7)) * 4 + 32'($urandom_range(0, 3));
            default: addr = 32'($urandom_range(0, 1023));
         endcase
         do_req(1'($urandom), addr, $urandom);
      end
      drain();

      // LATENCY=1 instance: four writes then eight back-to-back reads
      @(negedge clk);
      apply_reset();
      prev_acc = 0;
      for (int i = 0; i < 12; i++) begin
         n = 0;
         @(negedge clk);
         while (!req_ready1 && n < 50) begin
            @(negedge clk);
            n++;
         end
         if (!req_ready1) begin
            check("accept_timeout1", req_ready1, 1);
            break;
         end
         req_v1    = 1'b1;
         req_we1   = (i < 4);
         req_addr1 = 32'(i % 4) * 8 + 32'(i % 3);
         req_data1 = $urandom;
         predict(req_we1, req_addr1, req_data1, e);
         e.acc = edge_cnt + 1;
         q1.push_back(e);
         if (i > 0) check("spacing1", e.acc - prev_acc, 2);
         prev_acc = e.acc;
         @(posedge clk);
         #1;
         req_v1 = 1'b0;
      end
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end

endmodule

// File: doc/line_mem_responder.md
Name: line_mem_responder

Overview:
- Backing-memory responder on the memory side of the direct-mapped cache.
- Services line fills (reads) and dirty-line writebacks (writes) from the cache controller over a valid/ready request/response handshake.
- One request outstanding at a time; response returned after a programmable latency.
- Used as the main-memory model and as the synthesizable on-chip backing store for cache benches.

Parameters:
WIDTH, 32, address width in bits
B, 4, line size in bytes; data path is B*8 bits
DEPTH, 256, number of lines stored; power of two
LATENCY, 4, cycles from request acceptance to resp_v_o rising; legal range 1..255

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
req_v_i  input  1  request valid
req_ready_o  output  1  responder can accept a request
req_we_i  input  1  1 = writeback, 0 = line fill
req_addr_i  input  WIDTH  byte address; low clog2(B) bits ignored
req_data_i  input  B*8  writeback line data
resp_v_o  output  1  response valid
resp_ready_i  input  1  requester accepts response
resp_we_o  output  1  echo of the accepted request's req_we_i
resp_data_o  output  B*8  read data; 0 for writes and for errors
resp_err_o  output  1  address out of range

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Address decode:
  - line index = req_addr_i[clog2(B)+clog2(DEPTH)-1 : clog2(B)].
  - Out of range = any bit above the index field is set.
- Storage is DEPTH x B*8 bits.
- Reset (rst high at a posedge):
  - All memory lines cleared to 0; state goes to IDLE.
  - req_ready_o=1 after reset deasserts; resp_v_o=0, resp_we_o=0, resp_data_o=0, resp_err_o=0.
  - Reset overrides every other event in the same cycle.
- FSM has three states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready_o=1.
  - On req_v_i & req_ready_o at a posedge: latch addr, we and data; load cnt=LATENCY-1.
  - If LATENCY==1, go to RESP and commit the access at that edge; otherwise go to WAIT.
- WAIT:
  - req_ready_o=0; cnt decrements each cycle.
  - At the edge where cnt==1, commit the access and go to RESP.
- Commit, all at the same edge:
  - Read: resp_data_o <= mem[index].
  - Write: mem[index] <= latched data and resp_data_o <= 0.
  - resp_err_o <= out-of-range. An out-of-range write is dropped (memory unchanged) and an out-of-range read returns 0.
  - resp_we_o <= latched we.
- RESP:
  - resp_v_o=1; req_ready_o=0.
  - resp_* outputs are held stable until resp_v_o & resp_ready_i at a posedge, then go to IDLE.
  - resp_v_o falls in the next cycle, and resp_data_o/resp_err_o return to 0.
- Latency: a request accepted at edge k gives resp_v_o high from the cycle after edge k+LATENCY-1, i.e. visible LATENCY cycles after acceptance.
- Back-to-back requests: the earliest next acceptance is the cycle after the response handshake, because req_ready_o goes high in IDLE. There is no request/response overlap.
- Ordering: a read issued after a write to the same line returns the written data.
- req_v_i asserted while req_ready_o=0 is ignored; the requester must hold it.
- Payload (req_we_i, req_addr_i, req_data_i) is sampled only at the acceptance edge and ignored afterwards.
- rst during WAIT: the pending write is not committed, and no response is produced.
- rst during RESP: the response is dropped, even if the write was already committed; the memory is cleared by the reset anyway.

Test Plan:
- Reset, then read addr 0x0000_0010 with LATENCY=4 -> accept at edge k; resp_v_o seen 4 cycles later; resp_data_o=0, resp_err_o=0, resp_we_o=0.
- Write 0xDEADBEEF to 0x0000_0040, then read 0x0000_0042 (same line, offset ignored) -> write resp_we_o=1, resp_data_o=0; read returns 0xDEADBEEF.
- Write to 0x0000_0400 (index wraps past DEPTH=256 lines, upper bit set) -> resp_err_o=1, and a subsequent read of 0x0000_0000 returns 0.
- Hold resp_ready_i=0 for 5 cycles during RESP -> resp_v_o and resp_data_o stay stable, req_ready_o=0, and a new req_v_i is not accepted; release -> IDLE the next cycle.
- Assert rst two cycles into WAIT of a write of 0x12345678 to 0x80 -> no response; a later read of 0x80 returns 0.
- LATENCY=1 build: 8 back-to-back reads with resp_ready_i tied high -> each response arrives 1 cycle after acceptance, and acceptances are spaced 2 cycles apart.
